reset_sequencer: RTL and testbench

Parametrised power-on reset sequencer for the board top level. It holds CHANNELS downstream reset outputs asserted until every PLL lock input is stable, waits a power-on delay, then releases the channels one at a time in index order with a fixed gap between releases. Loss of lock or a soft-reset request re-asserts all channels, and the release sequence runs again. It sits between the clock generation block and the capture, SDRAM and display subsystems.

---
 rtl/rst_seq_pkg.sv | 24 ++
 rtl/lock_sync_filter.sv | 58 +++++
 rtl/reset_sequencer.sv | 144 ++++++++++++++
 tb/tb_reset_sequencer.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/rst_seq_pkg.sv
// Shared types and helpers for the board reset sequencer.
// Holds the FSM state encoding and the counter-width function.
package rst_seq_pkg;

  typedef enum logic [1:0] {
    S_HOLD = 2'd0,
    S_POR  = 2'd1,
    S_STEP = 2'd2,
    S_RUN  = 2'd3
  } state_t;

  function automatic int cnt_width(
    input int a,
    input int b,
    input int c
  );
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/lock_sync_filter.sv
// 2-flop sync of each PLL lock flag, AND-reduced into lock_ok.
// Ports: clk, rst_n, pll_locked[LOCKS] in; lock_ok out. Macro: RST_SEQ_LOCK_FILT_EN.
module lock_sync_filter
  import rst_seq_pkg::*;
#(
  parameter int LOCKS = 2
`ifdef RST_SEQ_LOCK_FILT_EN
  ,
  parameter int LOCK_FILT = 64
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [LOCKS-1:0] pll_locked,
  output logic             lock_ok
);

  logic [LOCKS-1:0] sync1;
  logic [LOCKS-1:0] sync2;
  logic             all_lk;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= pll_locked;
      sync2 <= sync1;
    end
  end

  assign all_lk = &sync2;

`ifdef RST_SEQ_LOCK_FILT_EN
  localparam int FW = cnt_width(LOCK_FILT, 1, 1);
  localparam logic [FW-1:0] F_END = FW'(LOCK_FILT - 1);

  logic [FW-1:0] fcnt;

  // Saturates at F_END; lock_ok stays high until the AND drops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fcnt    <= '0;
      lock_ok <= 1'b0;
    end else if (!all_lk) begin
      fcnt    <= '0;
      lock_ok <= 1'b0;
    end else if (fcnt == F_END) begin
      lock_ok <= 1'b1;
    end else begin
      fcnt <= fcnt + 1'b1;
    end
  end
`else
  assign lock_ok = all_lk;
`endif

endmodule

// File: rtl/reset_sequencer.sv
// Power-on reset sequencer: holds, delays, then releases channels in order.
// Ports: clk, rst_n, pll_locked, soft_rst_req in; rst_out_n, all_ready, busy out.
// Macro RST_SEQ_LOCK_FILT_EN adds a LOCK_FILT-cycle lock stability filter.
module reset_sequencer
  import rst_seq_pkg::*;
#(
  parameter int CHANNELS   = 4,
  parameter int LOCKS      = 2,
  parameter int MIN_HOLD   = 16,
  parameter int POR_DELAY  = 1000,
  parameter int STEP_DELAY = 100,
  parameter int LOCK_FILT  = 64
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [LOCKS-1:0]    pll_locked,
  input  logic                soft_rst_req,
  output logic [CHANNELS-1:0] rst_out_n,
  output logic                all_ready,
  output logic                busy
);

  localparam int CW = cnt_width(MIN_HOLD, POR_DELAY, STEP_DELAY);
  localparam int XW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam logic [CW-1:0] H_END = CW'(MIN_HOLD - 1);
  localparam logic [CW-1:0] P_END = CW'(POR_DELAY - 1);
  localparam logic [CW-1:0] S_END = CW'(STEP_DELAY - 1);
  localparam logic [XW-1:0] LAST  = XW'(CHANNELS - 1);

  if (CHANNELS < 1 || CHANNELS > 16 || LOCKS < 1 || LOCKS > 8 ||
      MIN_HOLD < 1 || POR_DELAY < 1 || STEP_DELAY < 1 ||
      LOCK_FILT < 1) begin : g_bad_cfg
    $error("reset_sequencer: parameter out of range");
  end

  logic lock_ok;
  logic abort;

  lock_sync_filter #(
    .LOCKS(LOCKS)
`ifdef RST_SEQ_LOCK_FILT_EN
    ,
    .LOCK_FILT(LOCK_FILT)
`endif
  ) u_lock (
    .clk       (clk),
    .rst_n     (rst_n),
    .pll_locked(pll_locked),
    .lock_ok   (lock_ok)
  );

  state_t              state, nxt;
  logic [CW-1:0]       cnt, cnt_n;
  logic [XW-1:0]       ch, ch_n;
  logic [CHANNELS-1:0] rst_d;
  logic                ready_d;
  logic                busy_d;

  assign abort = !lock_ok || soft_rst_req;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_HOLD;
      cnt       <= '0;
      ch        <= '0;
      rst_out_n <= '0;
      all_ready <= 1'b0;
      busy      <= 1'b1;
    end else begin
      state     <= nxt;
      cnt       <= cnt_n;
      ch        <= ch_n;
      rst_out_n <= rst_d;
      all_ready <= ready_d;
      busy      <= busy_d;
    end
  end

  always_comb begin
    nxt     = state;
    cnt_n   = cnt;
    ch_n    = ch;
    rst_d   = rst_out_n;
    ready_d = 1'b0;
    busy_d  = 1'b1;
    unique case (state)
      S_HOLD: begin
        rst_d = '0;
        ch_n  = '0;
        // Any unlocked or soft-reset cycle restarts the hold count.
        if (abort) begin
          cnt_n = '0;
        end else if (cnt == H_END) begin
          nxt   = S_POR;
          cnt_n = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      S_POR: begin
        if (cnt == P_END) begin
          nxt      = S_STEP;
          cnt_n    = '0;
          ch_n     = '0;
          rst_d[0] = 1'b1;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      S_STEP: begin
        if (cnt == S_END) begin
          cnt_n = '0;
          if (ch == LAST) begin
            nxt     = S_RUN;
            ready_d = 1'b1;
            busy_d  = 1'b0;
          end else begin
            ch_n = ch + 1'b1;
            for (int i = 1; i < CHANNELS; i++) begin
              if (XW'(i) == ch + 1'b1) rst_d[i] = 1'b1;
            end
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      S_RUN: begin
        ready_d = 1'b1;
        busy_d  = 1'b0;
      end
      default: nxt = S_HOLD;
    endcase
    // Re-assert every channel together on lock loss or soft reset.
    if (abort && state != S_HOLD) begin
      nxt     = S_HOLD;
      cnt_n   = '0;
      ch_n    = '0;
      rst_d   = '0;
      ready_d = 1'b0;
      busy_d  = 1'b1;
    end
  end

endmodule

// File: tb/tb_reset_sequencer.sv
// Scoreboard bench for reset_sequencer: expected output changes are queued
// by the stimulus and matched by a monitor on every observed change.
module tb_reset_sequencer;

  localparam int CH = 3;
  localparam int LK = 2;
  localparam int MH = 8;
  localparam int PD = 10;
  localparam int SD = 4;
  localparam int LF = 16;
`ifdef RST_SEQ_LOCK_FILT_EN
  localparam int FL = LF;
  localparam int FX = 1;
`else
  localparam int FL = 0;
  localparam int FX = 0;
`endif
  localparam int T = 2 + FL + MH;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [LK-1:0] pll_locked = '1;
  logic          soft_rst_req = 1'b0;
  logic [CH-1:0] rst_out_n;
  logic          all_ready;
  logic          busy;

  int cyc = 0;
  int n_run = 0;
  int n_fail = 0;

  typedef struct {
    int            at;
    logic [CH+1:0] val;
  } ev_t;

  ev_t q[$];
  logic [CH+1:0] prev = {{CH{1'b0}}, 1'b0, 1'b1};

  reset_sequencer #(
    .CHANNELS  (CH),
    .LOCKS     (LK),
    .MIN_HOLD  (MH),
    .POR_DELAY (PD),
    .STEP_DELAY(SD),
    .LOCK_FILT (LF)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pll_locked  (pll_locked),
    .soft_rst_req(soft_rst_req),
    .rst_out_n   (rst_out_n),
    .all_ready   (all_ready),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin : mon
    logic [CH+1:0] cur;
    ev_t e;
    cur = {rst_out_n, all_ready, busy};
    if (cur !== prev) begin
      n_run++;
      if (q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_change: got %b at edge %0d, want no change",
                 cur, cyc);
      end else begin
        e = q.pop_front();
        if (e.at != cyc || e.val !== cur) begin
          n_fail++;
          $display("FAIL event: got %b at edge %0d, want %b at edge %0d",
                   cur, cyc, e.val, e.at);
        end
      end
    end
    prev = cur;
  end

  task automatic expect_ev(input int at, input logic [CH-1:0] r,
                           input logic a, input logic b);
    ev_t e;
    e.at  = at;
    e.val = {r, a, b};
    q.push_back(e);
  endtask

  // p is the edge at which the FSM enters POR.
  task automatic expect_seq(input int p);
    logic [CH-1:0] m;
    m = '0;
    for (int k = 0; k < CH; k++) begin
      m[k] = 1'b1;
      expect_ev(p + PD + k * SD, m, 1'b0, 1'b1);
    end
    expect_ev(p + PD + CH * SD, m, 1'b1, 1'b0);
  endtask

  task automatic to_neg(input int k);
    @(negedge clk);
    while (cyc < k) @(negedge clk);
  endtask

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_rst_out_n"}, 32'(rst_out_n), 32'd0);
    check({tag, "_all_ready"}, 32'(all_ready), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd1);
  endtask

  task automatic async_reset();
    @(posedge clk);
    #2 rst_n = 1'b0;
    expect_ev(cyc, '0, 1'b0, 1'b1);
    #1 check_reset_vals("async");
  endtask

  initial begin : stim
    int b, a, s, p, g, r;

    // Clean power-up.
    to_neg(3);
    check_reset_vals("por");
    rst_n = 1'b1;
    b = cyc;
    expect_seq(b + T);
    to_neg(b + T + PD + CH * SD + 3);

    // One-cycle lock loss in RUN.
    pll_locked = 2'b01;
    a = cyc + 1;
    expect_ev(a + 2 + FX, '0, 1'b0, 1'b1);
    expect_seq(a + 2 + FL + MH);
    @(negedge clk);
    pll_locked = '1;
    to_neg(a + 2 + FL + MH + PD + CH * SD + 3);

    // Soft reset in RUN, then again in HOLD to extend it.
    s = cyc + 1;
    soft_rst_req = 1'b1;
    expect_ev(s, '0, 1'b0, 1'b1);
    to_neg(s);
    soft_rst_req = 1'b0;
    to_neg(s + 3);
    soft_rst_req = 1'b1;
    to_neg(s + 4);
    soft_rst_req = 1'b0;
    expect_seq(s + 4 + MH);
    to_neg(s + 4 + MH + PD + CH * SD + 3);

    // Async reset mid-RUN, then soft reset mid-STEP.
    async_reset();
    to_neg(cyc + 3);
    rst_n = 1'b1;
    b = cyc;
    expect_ev(b + T + PD, CH'(1), 1'b0, 1'b1);
    p = b + T + PD + 2;
    to_neg(p - 1);
    soft_rst_req = 1'b1;
    expect_ev(p, '0, 1'b0, 1'b1);
    to_neg(p);
    soft_rst_req = 1'b0;
    expect_seq(p + MH);
    to_neg(p + MH + PD + CH * SD + 3);

`ifdef RST_SEQ_LOCK_FILT_EN
    // Five-cycle lock glitch while the filter is still counting in HOLD.
    async_reset();
    to_neg(cyc + 3);
    rst_n = 1'b1;
    b = cyc;
    g = b + 5;
    to_neg(g - 1);
    pll_locked = 2'b10;
    to_neg(g + 4);
    pll_locked = '1;
    r = g + 5;
    expect_seq(r + 1 + LF + MH);
    to_neg(r + 1 + LF + MH + PD + CH * SD + 3);
`else
    g = 0;
    r = g;
`endif

    to_neg(cyc + 2);
    check("queue_empty", 32'(q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
